// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus interface.
package rtc_pkg;

  localparam int unsigned ANCHO_BUS    = 8;
  localparam int unsigned ANCHO_INDICE = 3;
  localparam int unsigned N_REGISTROS  = 6;

  localparam logic [ANCHO_BUS-1:0] DIR_BASE_LECTURA = 8'h21;

  // Shadow bank slot order matches the RTC register order of a time burst.
  localparam int unsigned SEG  = 0;
  localparam int unsigned MIN  = 1;
  localparam int unsigned HORA = 2;
  localparam int unsigned DIA  = 3;
  localparam int unsigned MES  = 4;
  localparam int unsigned ANIO = 5;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    DIRECCION = 2'd1,
    DATO      = 2'd2,
    FIN       = 2'd3
  } estado_t;

endpackage

// File: rtl/detector_flancos.sv
// Registers one generator strobe and flags rising/falling edges of the registered copy.
module detector_flancos #(
  parameter logic VAL_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic sube_c,
  output logic baja_c
);

  logic q_ant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= VAL_RESET;
      q_ant <= VAL_RESET;
    end else begin
      q     <= d;
      q_ant <= q;
    end
  end

  assign sube_c = q & ~q_ant;
  assign baja_c = ~q & q_ant;

endmodule

// File: rtl/interfaz_bus_rtc.sv
// Drives the RTC multiplexed address/data bus: six-register read bursts into a
// shadow bank, or single address/data writes from the configuration logic.
module interfaz_bus_rtc
  import rtc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IndicadorMaquina,
  input  logic                 ChipSelect1,
  input  logic                 Read1,
  input  logic                 Write1,
  input  logic                 AoD1,
  input  logic [ANCHO_BUS-1:0] dir_escritura,
  input  logic [ANCHO_BUS-1:0] dato_escritura,
  inout  wire  [ANCHO_BUS-1:0] AD,
  output logic                 rtc_cs,
  output logic                 rtc_rd,
  output logic                 rtc_wr,
  output logic                 rtc_ad,
  output logic [ANCHO_BUS-1:0] segundos,
  output logic [ANCHO_BUS-1:0] minutos,
  output logic [ANCHO_BUS-1:0] horas,
  output logic [ANCHO_BUS-1:0] dia,
  output logic [ANCHO_BUS-1:0] mes,
  output logic [ANCHO_BUS-1:0] anio,
  output logic                 dato_valido,
  output logic                 ocupado,
  output logic                 error_bus
);

  estado_t estado, estado_sig;

  logic                                   cs_sube_c, cs_baja_c, aod_sube_c, rd_sube_c;
  logic                                   aod_baja_unused, rd_baja_unused;
  logic                                   modo, err_tx, hay_dato, ad_oe;
  logic [ANCHO_INDICE-1:0]                indice, indice_c;
  logic [ANCHO_BUS-1:0]                   muestra, ad_dato, ad_dato_c;
  logic [N_REGISTROS-1:0][ANCHO_BUS-1:0] banco;
  logic                                   modo_c, ad_oe_c, err_now_c, commit_c, ultimo_c;

  detector_flancos #(.VAL_RESET(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(ChipSelect1), .q(rtc_cs),
    .sube_c(cs_sube_c), .baja_c(cs_baja_c)
  );

  detector_flancos #(.VAL_RESET(1'b1)) u_aod (
    .clk(clk), .reset(reset), .d(AoD1), .q(rtc_ad),
    .sube_c(aod_sube_c), .baja_c(aod_baja_unused)
  );

  detector_flancos #(.VAL_RESET(1'b1)) u_rd (
    .clk(clk), .reset(reset), .d(Read1), .q(rtc_rd),
    .sube_c(rd_sube_c), .baja_c(rd_baja_unused)
  );

  // Next-state logic.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      REPOSO:    if (cs_baja_c) estado_sig = DIRECCION;
      DIRECCION: if (cs_sube_c) estado_sig = FIN;
                 else if (aod_sube_c) estado_sig = DATO;
      DATO:      if (cs_sube_c) estado_sig = FIN;
      FIN:       estado_sig = REPOSO;
      default:   estado_sig = REPOSO;
    endcase
  end

  // Bus drive is decided from the raw strobes so enable/value land with rtc_wr/rtc_ad;
  // before the mode is latched, the incoming mode and its index-clear are used directly.
  always_comb begin
    modo_c    = (estado == REPOSO) ? IndicadorMaquina : modo;
    indice_c  = (estado == REPOSO && IndicadorMaquina != modo) ? '0 : indice;
    err_now_c = ~Read1 & ~Write1;
    ad_oe_c   = ~ChipSelect1 & ~Write1 & Read1 & ~(modo_c & AoD1);
    ad_dato_c = AoD1   ? dato_escritura :
                modo_c ? DIR_BASE_LECTURA + ANCHO_BUS'(indice_c) : dir_escritura;
    commit_c  = (estado == DATO) & modo & rd_sube_c & ~err_tx;
    ultimo_c  = (indice == ANCHO_INDICE'(N_REGISTROS - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= REPOSO;
      rtc_wr      <= 1'b1;
      ad_oe       <= 1'b0;
      ad_dato     <= '0;
      modo        <= 1'b1;
      indice      <= '0;
      banco       <= '0;
      muestra     <= '0;
      err_tx      <= 1'b0;
      hay_dato    <= 1'b0;
      dato_valido <= 1'b0;
      ocupado     <= 1'b0;
      error_bus   <= 1'b0;
    end else begin
      estado      <= estado_sig;
      rtc_wr      <= Write1;
      ad_oe       <= ad_oe_c;
      ad_dato     <= ad_dato_c;
      ocupado     <= (estado_sig != REPOSO);
      dato_valido <= 1'b0;

      if (err_now_c) error_bus <= 1'b1;
      if (!rtc_rd) muestra <= AD;

      if (estado == REPOSO) begin
        err_tx   <= err_now_c;
        hay_dato <= 1'b0;
        if (cs_baja_c) begin
          modo <= IndicadorMaquina;
          if (IndicadorMaquina != modo) indice <= '0;
        end
      end else begin
        err_tx <= err_tx | err_now_c;
        if (commit_c) begin
          banco[indice] <= muestra;
          hay_dato      <= 1'b1;
        end
        // Index advances once per committing read, on entry to FIN.
        if (estado != FIN && estado_sig == FIN && (hay_dato || commit_c)) begin
          if (ultimo_c) begin
            indice      <= '0;
            dato_valido <= 1'b1;
          end else begin
            indice <= indice + ANCHO_INDICE'(1);
          end
        end
      end
    end
  end

  assign AD = ad_oe ? ad_dato : {ANCHO_BUS{1'bz}};

  assign segundos = banco[SEG];
  assign minutos  = banco[MIN];
  assign horas    = banco[HORA];
  assign dia      = banco[DIA];
  assign mes      = banco[MES];
  assign anio     = banco[ANIO];

endmodule

// File: doc/interfaz_bus_rtc.md
# interfaz_bus_rtc

Downstream stage of `GeneradorFunciones`: consumes its bus strobes (`ChipSelect1`, `Read1`, `Write1`, `AoD1`) and the mode flag `IndicadorMaquina`, and drives the RTC's multiplexed 8-bit address/data bus. In read mode it runs a six-register time burst and captures the results into a shadow bank for the display path. In write mode it sends one address/data pair from the configuration logic.

## Interface
- `DIR_BASE_LECTURA`, 8'h21: RTC address of the first burst register (seconds).
- `N_REGISTROS`, 6: registers per read burst (seconds, minutes, hours, day, month, year).
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `IndicadorMaquina` input 1: 1 = read burst mode, 0 = single write mode.
- `ChipSelect1` input 1: active-low chip select from generator.
- `Read1` input 1: active-low read strobe.
- `Write1` input 1: active-low write strobe.
- `AoD1` input 1: 0 = address phase, 1 = data phase.
- `dir_escritura` input 8: RTC address for write mode.
- `dato_escritura` input 8: data for write mode.
- `AD` inout 8: RTC multiplexed address/data bus.
- `rtc_cs`, `rtc_rd`, `rtc_wr`, `rtc_ad` output 1 each: registered copies of the generator strobes, same polarity.
- `segundos`, `minutos`, `horas`, `dia`, `mes`, `anio` output 8 each: shadow bank, raw BCD.
- `dato_valido` output 1: one-cycle pulse when a full burst has been captured.
- `ocupado` output 1: high from CS falling edge until the FIN state exits.
- `error_bus` output 1: sticky flag set when `Read1` and `Write1` are both low in one cycle. Cleared only by reset.

## Operation
- FSM states: REPOSO, DIRECCION, DATO, FIN.
- REPOSO -> DIRECCION: registered `ChipSelect1` falls. On this transition `IndicadorMaquina` is latched as the transaction mode.
- DIRECCION -> DATO: registered `AoD1` rises.
- DATO -> FIN: registered `ChipSelect1` rises.
- FIN -> REPOSO: unconditional, after one cycle.
- Registered `ChipSelect1` rising while in DIRECCION: transaction aborted. No capture, no index change, next state FIN.
- Address phase, `rtc_wr` low: `AD` driven with `DIR_BASE_LECTURA + indice` in read mode, or with `dir_escritura` in write mode.
- Write data phase, `rtc_wr` low: `AD` driven with `dato_escritura`.
- Read data phase: `AD` is high-Z. `AD` is sampled every cycle `rtc_rd` is low. The last sample is committed to bank slot `indice` on the registered `Read1` rising edge.
- The `AD` output enable is never asserted while `rtc_rd` is low.
- `indice` is 3 bits, 0..`N_REGISTROS`-1. It increments at FIN of each read transaction that committed data.
- When the committed slot is `N_REGISTROS`-1, `indice` wraps to 0 and `dato_valido` pulses in the FIN cycle.
- Write transactions leave `indice` and the bank untouched.
- If the latched mode differs from the previous transaction's mode, `indice` clears to 0 at DIRECCION entry, discarding any partial burst.
- `Read1` and `Write1` both low: `error_bus` is set, `AD` is released, and the bank is not written for that transaction.

## Timing
- All outputs are registered. The `rtc_*` strobes lag the generator inputs by exactly 1 clk.
- The `AD` enable and value change in the same cycle as `rtc_wr`/`rtc_ad`.
- Bank update becomes visible the cycle after the registered `Read1` rising edge.
- `dato_valido` is high for exactly 1 cycle, coincident with the last bank update.
- Reset values:
  - `rtc_cs`, `rtc_rd`, `rtc_wr`, `rtc_ad` = 1.
  - `AD` high-Z.
  - Bank = 8'h00; `indice` = 0; previous mode = 1.
  - `dato_valido`, `ocupado`, `error_bus` = 0; state REPOSO.
- Reset asserted mid-transaction: `AD` is released immediately (asynchronously). The partial bank write is discarded. Already-committed bank slots are also cleared to reset values.

## Structure
- Package `rtc_pkg`:
  - FSM state enum.
  - `DIR_BASE_LECTURA` default and bank slot index constants (SEG=0 .. ANIO=5).
  - 8-bit bus width constant.
- Sub-module `detector_flancos`: registers one strobe and emits rise/fall pulses. Instantiated for `ChipSelect1`, `AoD1` and `Read1`.
- Top level holds the FSM, the `AD` tristate and the shadow bank.

## Test plan
- Write mode, `dir_escritura`=8'h21, `dato_escritura`=8'h45 -> `AD`=8'h21 while `rtc_wr` is low in the address phase, then 8'h45 in the data phase; bank unchanged; no `dato_valido`.
- Read burst, RTC model returning 8'h30,8'h59,8'h23,8'h15,8'h08,8'h24 -> addresses 8'h21..8'h26 in order; bank holds those values; one `dato_valido` pulse after the sixth transaction; `indice` back to 0.
- Two consecutive bursts with the second returning new seconds 8'h31 -> `segundos` updates, `dato_valido` pulses once per burst.
- `IndicadorMaquina` toggled to 0 after three reads, then back to 1 -> `indice` clears; the next read addresses 8'h21.
- Reset pulsed while `rtc_rd` is low in the data phase -> `AD` high-Z the same cycle; all outputs at reset values; the next burst restarts at 8'h21.
- `Read1` and `Write1` both forced low for one cycle -> `error_bus`=1 and stays 1; `AD` high-Z; bank unchanged.
